// File: rtl/vending_sale_ctrl_pkg.sv
// Shared vending definitions: state encodings and default sale parameters.
// Used by the sale sequencer, the FSM top and the display decoder.
package vending_sale_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_COUNT    = 3'd1,
    ST_WAIT_ACC = 3'd2,
    ST_DISPENSE = 3'd3,
    ST_REFUND   = 3'd4
  } state_t;

  localparam int DEF_PRICE    = 3;
  localparam int DEF_CREDIT_W = 3;
  localparam int DEF_DISP_CYC = 4;
  localparam int DEF_TIMEOUT  = 1000;

  function automatic logic is_busy(input state_t s);
    return (s == ST_DISPENSE) || (s == ST_REFUND);
  endfunction

endpackage

// File: rtl/vending_sale_ctrl_sync_edge.sv
// Two-flop synchroniser for an asynchronous button/sensor level,
// followed by a rising-edge detector producing a 1-cycle pulse.
module vending_sale_ctrl_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_raw;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/vending_sale_ctrl.sv
// Vending sale sequencer: coin credit, accept, timed dispense, change refund,
// with cancel and idle-timeout paths. All outputs come straight from flops.
module vending_sale_ctrl
  import vending_sale_ctrl_pkg::*;
#(
  parameter int PRICE    = DEF_PRICE,
  parameter int CREDIT_W = DEF_CREDIT_W,
  parameter int DISP_CYC = DEF_DISP_CYC,
  parameter int TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_i,
  input  logic                accept_i,
  input  logic                cancel_i,
  output logic [CREDIT_W-1:0] credit_o,
  output logic                disp_o,
  output logic                refund_o,
  output logic                coin_rej_o,
  output logic                busy_o,
  output logic [2:0]          state_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int DW = $clog2(DISP_CYC + 1);
  localparam logic [CREDIT_W-1:0] LP_PRICE = CREDIT_W'(PRICE);
  localparam logic [CREDIT_W-1:0] CMAX     = '1;

  logic w_coin;
  logic w_acc;
  logic w_cancel;

  vending_sale_ctrl_sync_edge u_coin (
    .clk(clk), .rst(rst), .i_raw(coin_i), .o_rise(w_coin)
  );
  vending_sale_ctrl_sync_edge u_acc (
    .clk(clk), .rst(rst), .i_raw(accept_i), .o_rise(w_acc)
  );
  vending_sale_ctrl_sync_edge u_cancel (
    .clk(clk), .rst(rst), .i_raw(cancel_i), .o_rise(w_cancel)
  );

  state_t              r_state;
  logic [CREDIT_W-1:0] r_credit;
  logic [TW-1:0]       r_tmr;
  logic [DW-1:0]       r_dcnt;
  logic                r_disp;
  logic                r_refund;
  logic                r_rej;
  logic                r_busy;

  state_t              w_nxt;
  logic [CREDIT_W-1:0] w_credit;
  logic [TW-1:0]       w_tmr;
  logic [DW-1:0]       w_dcnt;
  logic                w_refund;
  logic                w_rej;
  logic                w_enter_ref;

  always_comb begin
    w_nxt       = r_state;
    w_credit    = r_credit;
    w_tmr       = r_tmr;
    w_dcnt      = r_dcnt;
    w_refund    = 1'b0;
    w_rej       = 1'b0;
    w_enter_ref = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_coin) begin
          w_credit = CREDIT_W'(1);
          w_tmr    = '0;
          w_nxt    = (PRICE == 1) ? ST_WAIT_ACC : ST_COUNT;
        end
      end
      ST_COUNT, ST_WAIT_ACC: begin
        // cancel > accept > coin; a losing coin is rejected
        if (w_cancel) begin
          w_enter_ref = 1'b1;
          w_rej       = w_coin;
        end else if (w_acc) begin
          w_tmr = '0;
          w_rej = w_coin;
          if (r_state == ST_WAIT_ACC) begin
            w_credit = r_credit - LP_PRICE;
            w_dcnt   = '0;
            w_nxt    = ST_DISPENSE;
          end
        end else if (w_coin) begin
          if (r_credit == CMAX) begin
            w_rej = 1'b1;
          end else begin
            w_tmr    = '0;
            w_credit = r_credit + 1'b1;
            if (w_credit >= LP_PRICE) w_nxt = ST_WAIT_ACC;
          end
        end else if (r_tmr == TW'(TIMEOUT - 1)) begin
          w_enter_ref = 1'b1;
        end else begin
          w_tmr = r_tmr + 1'b1;
        end
      end
      ST_DISPENSE: begin
        w_rej = w_coin;
        if (r_dcnt == DW'(DISP_CYC - 1)) begin
          if (r_credit != '0) w_enter_ref = 1'b1;
          else                w_nxt       = ST_IDLE;
        end else begin
          w_dcnt = r_dcnt + 1'b1;
        end
      end
      ST_REFUND: begin
        w_rej = w_coin;
        if (!r_refund) begin
          if (r_credit == '0) begin
            w_nxt = ST_IDLE;
          end else begin
            w_refund = 1'b1;
            w_credit = r_credit - 1'b1;
          end
        end
      end
      default: w_nxt = ST_IDLE;
    endcase
    // first refund pulse lands on the entry edge, so the pattern starts high
    if (w_enter_ref) begin
      w_nxt    = ST_REFUND;
      w_refund = 1'b1;
      w_credit = w_credit - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_credit <= '0;
      r_tmr    <= '0;
      r_dcnt   <= '0;
      r_disp   <= 1'b0;
      r_refund <= 1'b0;
      r_rej    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_nxt;
      r_credit <= w_credit;
      r_tmr    <= w_tmr;
      r_dcnt   <= w_dcnt;
      r_disp   <= (w_nxt == ST_DISPENSE);
      r_refund <= w_refund;
      r_rej    <= w_rej;
      r_busy   <= is_busy(w_nxt);
    end
  end

  assign credit_o   = r_credit;
  assign disp_o     = r_disp;
  assign refund_o   = r_refund;
  assign coin_rej_o = r_rej;
  assign busy_o     = r_busy;
  assign state_o    = r_state;

endmodule

// File: tb/tb_vending_sale_ctrl.sv
// Directed bench for vending_sale_ctrl: sale, change, cancel, timeout,
// saturation, simultaneous edges and mid-sale reset.
module tb_vending_sale_ctrl;

  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          coin_i;
  logic          accept_i;
  logic          cancel_i;
  logic [CW-1:0] credit_o;
  logic          disp_o;
  logic          refund_o;
  logic          coin_rej_o;
  logic          busy_o;
  logic [2:0]    state_o;

  int n_tot = 0;
  int n_bad = 0;

  vending_sale_ctrl #(
    .PRICE(3), .CREDIT_W(CW), .DISP_CYC(4), .TIMEOUT(20)
  ) dut (
    .clk(clk), .rst(rst),
    .coin_i(coin_i), .accept_i(accept_i), .cancel_i(cancel_i),
    .credit_o(credit_o), .disp_o(disp_o), .refund_o(refund_o),
    .coin_rej_o(coin_rej_o), .busy_o(busy_o), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // raw pulse for one cycle; returns just after the edge that acts on it
  task automatic press(input logic c, input logic a, input logic k);
    coin_i   = c;
    accept_i = a;
    cancel_i = k;
    tick();
    coin_i   = 1'b0;
    accept_i = 1'b0;
    cancel_i = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    coin_i = 1'b0;
    accept_i = 1'b0;
    cancel_i = 1'b0;
    repeat (3) tick();
    n_tot++;
    if ({state_o, credit_o, disp_o, refund_o, coin_rej_o, busy_o} !== 10'd0) begin
      n_bad++;
      $display("FAIL reset_outs: got %b want 0",
        {state_o, credit_o, disp_o, refund_o, coin_rej_o, busy_o});
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_exact_sale();
    int nd;
    int nr;
    nd = 0;
    nr = 0;
    press(1, 0, 0);
    press(1, 0, 0);
    n_tot++;
    if ({state_o, credit_o} !== {3'd1, 3'd2}) begin
      n_bad++;
      $display("FAIL exact_count: got st=%0d cr=%0d want st=1 cr=2", state_o, credit_o);
    end
    press(1, 0, 0);
    n_tot++;
    if ({state_o, credit_o} !== {3'd2, 3'd3}) begin
      n_bad++;
      $display("FAIL exact_wait: got st=%0d cr=%0d want st=2 cr=3", state_o, credit_o);
    end
    press(0, 1, 0);
    n_tot++;
    if ({state_o, credit_o, disp_o, busy_o} !== {3'd3, 3'd0, 1'b1, 1'b1}) begin
      n_bad++;
      $display("FAIL exact_disp: got st=%0d cr=%0d d=%b b=%b want 3 0 1 1",
        state_o, credit_o, disp_o, busy_o);
    end
    for (int i = 0; i < 10; i++) begin
      if (disp_o)   nd++;
      if (refund_o) nr++;
      tick();
    end
    n_tot++;
    if (nd !== 4) begin
      n_bad++;
      $display("FAIL exact_disp_len: got %0d want 4", nd);
    end
    n_tot++;
    if (nr !== 0) begin
      n_bad++;
      $display("FAIL exact_no_refund: got %0d want 0", nr);
    end
    n_tot++;
    if ({state_o, credit_o, busy_o} !== {3'd0, 3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL exact_idle: got st=%0d cr=%0d b=%b want 0 0 0",
        state_o, credit_o, busy_o);
    end
  endtask

  task automatic test_change();
    for (int i = 0; i < 5; i++) press(1, 0, 0);
    n_tot++;
    if ({state_o, credit_o} !== {3'd2, 3'd5}) begin
      n_bad++;
      $display("FAIL change_five: got st=%0d cr=%0d want 2 5", state_o, credit_o);
    end
    press(0, 1, 0);
    n_tot++;
    if ({state_o, credit_o} !== {3'd3, 3'd2}) begin
      n_bad++;
      $display("FAIL change_accept: got st=%0d cr=%0d want 3 2", state_o, credit_o);
    end
    repeat (4) tick();
    n_tot++;
    if ({state_o, refund_o, credit_o, disp_o} !== {3'd4, 1'b1, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL change_r1: got st=%0d r=%b cr=%0d d=%b want 4 1 1 0",
        state_o, refund_o, credit_o, disp_o);
    end
    tick();
    n_tot++;
    if ({refund_o, credit_o} !== {1'b0, 3'd1}) begin
      n_bad++;
      $display("FAIL change_r2: got r=%b cr=%0d want 0 1", refund_o, credit_o);
    end
    tick();
    n_tot++;
    if ({refund_o, credit_o} !== {1'b1, 3'd0}) begin
      n_bad++;
      $display("FAIL change_r3: got r=%b cr=%0d want 1 0", refund_o, credit_o);
    end
    tick();
    n_tot++;
    if ({state_o, refund_o, credit_o} !== {3'd4, 1'b0, 3'd0}) begin
      n_bad++;
      $display("FAIL change_r4: got st=%0d r=%b cr=%0d want 4 0 0",
        state_o, refund_o, credit_o);
    end
    tick();
    n_tot++;
    if ({state_o, busy_o} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL change_idle: got st=%0d b=%b want 0 0", state_o, busy_o);
    end
  endtask

  task automatic test_cancel();
    int nd;
    int nr;
    nd = 0;
    nr = 0;
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 0, 1);
    n_tot++;
    if ({state_o, refund_o, credit_o} !== {3'd4, 1'b1, 3'd1}) begin
      n_bad++;
      $display("FAIL cancel_enter: got st=%0d r=%b cr=%0d want 4 1 1",
        state_o, refund_o, credit_o);
    end
    for (int i = 0; i < 8; i++) begin
      if (disp_o)   nd++;
      if (refund_o) nr++;
      tick();
    end
    n_tot++;
    if ({nr[3:0], nd[3:0]} !== {4'd2, 4'd0}) begin
      n_bad++;
      $display("FAIL cancel_pulses: got refunds=%0d disp=%0d want 2 0", nr, nd);
    end
    n_tot++;
    if ({state_o, credit_o} !== {3'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL cancel_idle: got st=%0d cr=%0d want 0 0", state_o, credit_o);
    end
  endtask

  task automatic test_timeout();
    press(1, 0, 0);
    repeat (19) tick();
    n_tot++;
    if ({state_o, credit_o} !== {3'd1, 3'd1}) begin
      n_bad++;
      $display("FAIL timeout_early: got st=%0d cr=%0d want 1 1", state_o, credit_o);
    end
    tick();
    n_tot++;
    if ({state_o, refund_o, credit_o} !== {3'd4, 1'b1, 3'd0}) begin
      n_bad++;
      $display("FAIL timeout_fire: got st=%0d r=%b cr=%0d want 4 1 0",
        state_o, refund_o, credit_o);
    end
    tick();
    n_tot++;
    if ({state_o, refund_o} !== {3'd4, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_low: got st=%0d r=%b want 4 0", state_o, refund_o);
    end
    tick();
    n_tot++;
    if ({state_o, refund_o} !== {3'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL timeout_idle: got st=%0d r=%b want 0 0", state_o, refund_o);
    end
  endtask

  task automatic test_saturation();
    int nr;
    int nj;
    nr = 0;
    nj = 0;
    for (int i = 0; i < 7; i++) press(1, 0, 0);
    n_tot++;
    if ({state_o, credit_o, coin_rej_o} !== {3'd2, 3'd7, 1'b0}) begin
      n_bad++;
      $display("FAIL sat_seven: got st=%0d cr=%0d rej=%b want 2 7 0",
        state_o, credit_o, coin_rej_o);
    end
    press(1, 0, 0);
    n_tot++;
    if ({credit_o, coin_rej_o} !== {3'd7, 1'b1}) begin
      n_bad++;
      $display("FAIL sat_reject: got cr=%0d rej=%b want 7 1", credit_o, coin_rej_o);
    end
    tick();
    n_tot++;
    if (coin_rej_o !== 1'b0) begin
      n_bad++;
      $display("FAIL sat_rej_width: got %b want 0", coin_rej_o);
    end
    press(0, 1, 0);
    n_tot++;
    if ({state_o, credit_o} !== {3'd3, 3'd4}) begin
      n_bad++;
      $display("FAIL sat_accept: got st=%0d cr=%0d want 3 4", state_o, credit_o);
    end
    press(1, 0, 0);
    n_tot++;
    if ({state_o, credit_o, coin_rej_o} !== {3'd3, 3'd4, 1'b1}) begin
      n_bad++;
      $display("FAIL sat_disp_coin: got st=%0d cr=%0d rej=%b want 3 4 1",
        state_o, credit_o, coin_rej_o);
    end
    for (int i = 0; i < 12; i++) begin
      if (refund_o)   nr++;
      if (coin_rej_o) nj++;
      tick();
    end
    n_tot++;
    if ({nr[3:0], nj[3:0]} !== {4'd4, 4'd1}) begin
      n_bad++;
      $display("FAIL sat_refunds: got refunds=%0d rej=%0d want 4 1", nr, nj);
    end
    n_tot++;
    if ({state_o, credit_o} !== {3'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL sat_idle: got st=%0d cr=%0d want 0 0", state_o, credit_o);
    end
  endtask

  task automatic test_cancel_coin();
    int nr;
    nr = 0;
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 0, 1);
    n_tot++;
    if ({state_o, coin_rej_o, refund_o, credit_o} !== {3'd4, 1'b1, 1'b1, 3'd1}) begin
      n_bad++;
      $display("FAIL cc_enter: got st=%0d rej=%b r=%b cr=%0d want 4 1 1 1",
        state_o, coin_rej_o, refund_o, credit_o);
    end
    for (int i = 0; i < 6; i++) begin
      if (refund_o) nr++;
      tick();
    end
    n_tot++;
    if (nr !== 2) begin
      n_bad++;
      $display("FAIL cc_refunds: got %0d want 2", nr);
    end
    n_tot++;
    if ({state_o, credit_o} !== {3'd0, 3'd0}) begin
      n_bad++;
      $display("FAIL cc_idle: got st=%0d cr=%0d want 0 0", state_o, credit_o);
    end
  endtask

  task automatic test_accept_early();
    press(1, 0, 0);
    press(0, 1, 0);
    n_tot++;
    if ({state_o, credit_o, disp_o} !== {3'd1, 3'd1, 1'b0}) begin
      n_bad++;
      $display("FAIL early_accept: got st=%0d cr=%0d d=%b want 1 1 0",
        state_o, credit_o, disp_o);
    end
    press(0, 0, 1);
    repeat (4) tick();
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) press(1, 0, 0);
    press(0, 1, 0);
    tick();
    n_tot++;
    if ({state_o, disp_o} !== {3'd3, 1'b1}) begin
      n_bad++;
      $display("FAIL rstmid_pre: got st=%0d d=%b want 3 1", state_o, disp_o);
    end
    rst = 1'b1;
    #1;
    n_tot++;
    if ({state_o, credit_o, disp_o, refund_o, coin_rej_o, busy_o} !== 10'd0) begin
      n_bad++;
      $display("FAIL rstmid_async: got %b want 0",
        {state_o, credit_o, disp_o, refund_o, coin_rej_o, busy_o});
    end
    #1;
    rst = 1'b0;
    repeat (3) tick();
    n_tot++;
    if ({state_o, credit_o, disp_o, refund_o} !== {3'd0, 3'd0, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL rstmid_after: got st=%0d cr=%0d d=%b r=%b want 0 0 0 0",
        state_o, credit_o, disp_o, refund_o);
    end
  endtask

  initial begin
    test_reset();
    test_exact_sale();
    test_change();
    test_cancel();
    test_timeout();
    test_saturation();
    test_cancel_coin();
    test_accept_early();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
